// File: rtl/reorder_queue_pkg.sv
// Shared types and constants for the reorder queue: reserved tags, jump-bit
// encodings and the per-slot entry record.
package reorder_queue_pkg;

    localparam int unsigned TAG_NONE  = 0;
    localparam int unsigned TAG_FIRST = 1;

    localparam int unsigned RQ_REG_W  = 5;
    localparam int unsigned RQ_DATA_W = 32;
    localparam int unsigned RQ_ADDR_W = 32;

    localparam logic JMP_NT = 1'b0;
    localparam logic JMP_T  = 1'b1;

    typedef struct packed {
        logic                 occupied;
        logic                 done;
        logic                 store;
        logic [RQ_REG_W-1:0]  regnm;
        logic [RQ_DATA_W-1:0] dt;
        logic                 pd;
        logic                 ac;
        logic [RQ_ADDR_W-1:0] j_pc;
    } rq_entry_t;

endpackage

// File: rtl/reorder_queue_ptr.sv
// Wrapping slot pointer for the reorder queue: counts 1..DEPTH-1 and never
// lands on the reserved tag 0.
module rq_ptr
    import reorder_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned TAG_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_clear,
    input  logic             i_inc,
    output logic [TAG_W-1:0] o_ptr
);

    logic [TAG_W-1:0] r_ptr;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_ptr <= TAG_W'(TAG_FIRST);
        end else if (i_en) begin
            if (i_clear) begin
                r_ptr <= TAG_W'(TAG_FIRST);
            end else if (i_inc) begin
                r_ptr <= (r_ptr == TAG_W'(DEPTH - 1)) ? TAG_W'(TAG_FIRST)
                                                       : r_ptr + TAG_W'(1);
            end
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/reorder_queue.sv
// In-order commit queue for out-of-order writebacks, with store handshake and
// mispredict flush. Optional query read ports are enabled by ROB_QUERY_EN.
module reorder_queue
    import reorder_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned TAG_W  = $clog2(DEPTH),
    parameter int unsigned REG_W  = RQ_REG_W,
    parameter int unsigned DATA_W = RQ_DATA_W,
    parameter int unsigned ADDR_W = RQ_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    output logic              full,
    input  logic              alloc_en,
    input  logic [REG_W-1:0]  alloc_regnm,
    input  logic              alloc_store,
    input  logic              alloc_pd,
    output logic              alloc_ok,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              ex_en,
    input  logic [TAG_W-1:0]  ex_tag,
    input  logic [DATA_W-1:0] ex_dt,
    input  logic              ex_ac,
    input  logic [ADDR_W-1:0] ex_j_pc,
    input  logic              lsb_en,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_dt,
    output logic              st_req,
    output logic [TAG_W-1:0]  st_tag,
    input  logic              st_ack,
    output logic              rf_en,
    output logic [REG_W-1:0]  rf_regnm,
    output logic [DATA_W-1:0] rf_dt,
    output logic [TAG_W-1:0]  rf_tag,
    output logic              clr,
    output logic [ADDR_W-1:0] clr_pc,
    output logic [TAG_W-1:0]  count
`ifdef ROB_QUERY_EN
    ,
    input  logic [TAG_W-1:0]  q0_tag,
    output logic              q0_rdy,
    output logic [DATA_W-1:0] q0_dt,
    input  logic [TAG_W-1:0]  q1_tag,
    output logic              q1_rdy,
    output logic [DATA_W-1:0] q1_dt
`endif
);

    rq_entry_t         r_slots [DEPTH];
    logic [TAG_W-1:0]  r_count;
    logic              r_full;
    logic              r_rf_en;
    logic [REG_W-1:0]  r_rf_regnm;
    logic [DATA_W-1:0] r_rf_dt;
    logic [TAG_W-1:0]  r_rf_tag;
    logic              r_clr;
    logic [ADDR_W-1:0] r_clr_pc;

    logic [TAG_W-1:0]  w_head;
    logic [TAG_W-1:0]  w_tail;
    rq_entry_t         w_head_e;
    logic              w_run;
    logic              w_commit_alu;
    logic              w_commit_st;
    logic              w_commit;
    logic              w_mispred;
    logic              w_ex_hit;
    logic              w_lsb_hit;
    logic [TAG_W-1:0]  w_count_nxt;

    rq_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_head (
        .i_clk(clk), .i_rst(rst), .i_en(rdy), .i_clear(r_clr),
        .i_inc(w_commit), .o_ptr(w_head)
    );

    rq_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tail (
        .i_clk(clk), .i_rst(rst), .i_en(rdy), .i_clear(r_clr),
        .i_inc(alloc_ok), .o_ptr(w_tail)
    );

    // A pending flush blocks every other state change for its one cycle.
    assign w_head_e     = r_slots[w_head];
    assign w_run        = rdy & ~r_clr;
    assign w_commit_alu = w_run & w_head_e.occupied & ~w_head_e.store & w_head_e.done;
    assign w_commit_st  = w_run & w_head_e.occupied & w_head_e.store & st_ack;
    assign w_commit     = w_commit_alu | w_commit_st;
    assign w_mispred    = w_commit_alu & ((w_head_e.ac == JMP_T) ^ (w_head_e.pd == JMP_T));

    assign alloc_ok  = alloc_en & rdy & rst & ~r_full & ~r_clr;
    assign alloc_tag = w_tail;

    assign w_ex_hit  = ex_en & (ex_tag != TAG_W'(TAG_NONE)) & r_slots[ex_tag].occupied;
    assign w_lsb_hit = lsb_en & (lsb_tag != TAG_W'(TAG_NONE)) & r_slots[lsb_tag].occupied
                     & ~(ex_en & (ex_tag == lsb_tag));

    assign w_count_nxt = r_count + TAG_W'(alloc_ok) - TAG_W'(w_commit);

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_slots[i].occupied <= 1'b0;
                r_slots[i].done     <= 1'b0;
            end
            r_count    <= '0;
            r_full     <= 1'b0;
            r_rf_en    <= 1'b0;
            r_rf_regnm <= '0;
            r_rf_dt    <= '0;
            r_rf_tag   <= '0;
            r_clr      <= 1'b0;
            r_clr_pc   <= '0;
        end else if (rdy) begin
            if (r_clr) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    r_slots[i].occupied <= 1'b0;
                end
                r_count <= '0;
                r_full  <= 1'b0;
                r_rf_en <= 1'b0;
                r_clr   <= 1'b0;
            end else begin
                if (alloc_ok) begin
                    r_slots[w_tail] <= '{occupied: 1'b1, done: 1'b0, store: alloc_store,
                                         regnm: RQ_REG_W'(alloc_regnm), dt: '0,
                                         pd: alloc_pd, ac: JMP_NT, j_pc: '0};
                end
                if (w_ex_hit) begin
                    r_slots[ex_tag].done <= 1'b1;
                    r_slots[ex_tag].dt   <= RQ_DATA_W'(ex_dt);
                    r_slots[ex_tag].ac   <= ex_ac;
                    r_slots[ex_tag].j_pc <= RQ_ADDR_W'(ex_j_pc);
                end
                if (w_lsb_hit) begin
                    r_slots[lsb_tag].done <= 1'b1;
                    r_slots[lsb_tag].dt   <= RQ_DATA_W'(lsb_dt);
                end
                if (w_commit) begin
                    r_slots[w_head].occupied <= 1'b0;
                end
                r_rf_en <= w_commit_alu & (w_head_e.regnm != '0);
                if (w_commit_alu) begin
                    r_rf_regnm <= REG_W'(w_head_e.regnm);
                    r_rf_dt    <= DATA_W'(w_head_e.dt);
                    r_rf_tag   <= w_head;
                end
                r_clr <= w_mispred;
                if (w_mispred) begin
                    r_clr_pc <= ADDR_W'(w_head_e.j_pc);
                end
                r_count <= w_count_nxt;
                r_full  <= (w_count_nxt == TAG_W'(DEPTH - 1));
            end
        end
    end

    // Pulses are held while rdy is low and only shown once rdy returns.
    assign rf_en    = r_rf_en & rdy;
    assign clr      = r_clr & rdy;
    assign st_req   = w_run & w_head_e.occupied & w_head_e.store;
    assign st_tag   = st_req ? w_head : '0;
    assign rf_regnm = r_rf_regnm;
    assign rf_dt    = r_rf_dt;
    assign rf_tag   = r_rf_tag;
    assign clr_pc   = r_clr_pc;
    assign count    = r_count;
    assign full     = r_full;

`ifdef ROB_QUERY_EN
    // Returns {ready, data} for a tag, forwarding this cycle's writeback.
    function automatic logic [DATA_W:0] rq_query(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] res;
        res = {r_slots[tag].occupied & r_slots[tag].done, DATA_W'(r_slots[tag].dt)};
        if ((tag != TAG_W'(TAG_NONE)) && r_slots[tag].occupied && w_run) begin
            if (ex_en && (ex_tag == tag)) begin
                res = {1'b1, ex_dt};
            end else if (lsb_en && (lsb_tag == tag)) begin
                res = {1'b1, lsb_dt};
            end
        end
        return res;
    endfunction

    assign {q0_rdy, q0_dt} = rq_query(q0_tag);
    assign {q1_rdy, q1_dt} = rq_query(q1_tag);
`endif

endmodule

// File: tb/tb_reorder_queue.sv
// Directed self-checking bench for reorder_queue (default build, DEPTH=32).
module tb_reorder_queue;

    localparam int unsigned DEPTH  = 32;
    localparam int unsigned TAG_W  = 5;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              rdy = 1'b1;
    logic              full;
    logic              alloc_en = 1'b0;
    logic [REG_W-1:0]  alloc_regnm = '0;
    logic              alloc_store = 1'b0;
    logic              alloc_pd = 1'b0;
    logic              alloc_ok;
    logic [TAG_W-1:0]  alloc_tag;
    logic              ex_en = 1'b0;
    logic [TAG_W-1:0]  ex_tag = '0;
    logic [DATA_W-1:0] ex_dt = '0;
    logic              ex_ac = 1'b0;
    logic [ADDR_W-1:0] ex_j_pc = '0;
    logic              lsb_en = 1'b0;
    logic [TAG_W-1:0]  lsb_tag = '0;
    logic [DATA_W-1:0] lsb_dt = '0;
    logic              st_req;
    logic [TAG_W-1:0]  st_tag;
    logic              st_ack = 1'b0;
    logic              rf_en;
    logic [REG_W-1:0]  rf_regnm;
    logic [DATA_W-1:0] rf_dt;
    logic [TAG_W-1:0]  rf_tag;
    logic              clr;
    logic [ADDR_W-1:0] clr_pc;
    logic [TAG_W-1:0]  count;

    int n_checks = 0;
    int n_errors = 0;

    reorder_queue #(
        .DEPTH(DEPTH), .TAG_W(TAG_W), .REG_W(REG_W), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .full(full),
        .alloc_en(alloc_en), .alloc_regnm(alloc_regnm), .alloc_store(alloc_store),
        .alloc_pd(alloc_pd), .alloc_ok(alloc_ok), .alloc_tag(alloc_tag),
        .ex_en(ex_en), .ex_tag(ex_tag), .ex_dt(ex_dt), .ex_ac(ex_ac), .ex_j_pc(ex_j_pc),
        .lsb_en(lsb_en), .lsb_tag(lsb_tag), .lsb_dt(lsb_dt),
        .st_req(st_req), .st_tag(st_tag), .st_ack(st_ack),
        .rf_en(rf_en), .rf_regnm(rf_regnm), .rf_dt(rf_dt), .rf_tag(rf_tag),
        .clr(clr), .clr_pc(clr_pc), .count(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input logic [REG_W-1:0] regnm, input logic store, input logic pd);
        alloc_en    = 1'b1;
        alloc_regnm = regnm;
        alloc_store = store;
        alloc_pd    = pd;
        tick();
        alloc_en    = 1'b0;
        alloc_store = 1'b0;
        alloc_pd    = 1'b0;
    endtask

    task automatic ex_wb(input int tag, input logic [DATA_W-1:0] dt, input logic ac,
                         input logic [ADDR_W-1:0] jpc);
        ex_en   = 1'b1;
        ex_tag  = TAG_W'(tag);
        ex_dt   = dt;
        ex_ac   = ac;
        ex_j_pc = jpc;
    endtask

    initial begin
        int waited;

        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_rf_en", 64'(rf_en), 64'd0);
        check("rst_clr", 64'(clr), 64'd0);
        check("rst_st_req", 64'(st_req), 64'd0);
        check("rst_st_tag", 64'(st_tag), 64'd0);
        check("rst_rf_tag", 64'(rf_tag), 64'd0);
        check("rst_clr_pc", 64'(clr_pc), 64'd0);
        check("rst_alloc_tag", 64'(alloc_tag), 64'd1);

        // Fill all 31 usable slots, then one more request must be refused.
        for (int i = 1; i <= 31; i++) begin
            alloc_en    = 1'b1;
            alloc_regnm = REG_W'(i);
            #1;
            check("fill_ok", 64'(alloc_ok), 64'd1);
            check("fill_tag", 64'(alloc_tag), 64'(i));
            tick();
        end
        #1;
        check("fill_full", 64'(full), 64'd1);
        check("fill_count", 64'(count), 64'd31);
        check("fill_32nd_ok", 64'(alloc_ok), 64'd0);
        alloc_en = 1'b0;
        do_reset();

        // Out-of-order writebacks commit in tag order on consecutive cycles.
        for (int i = 1; i <= 3; i++) alloc(REG_W'(i), 1'b0, 1'b0);
        ex_wb(3, 32'h30, 1'b0, '0);
        tick();
        ex_en   = 1'b0;
        lsb_en  = 1'b1;
        lsb_tag = TAG_W'(1);
        lsb_dt  = 32'h10;
        tick();
        lsb_en = 1'b0;
        ex_wb(2, 32'h20, 1'b0, '0);
        tick();
        ex_en = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("ooo_rf_en", 64'(rf_en), 64'd1);
            check("ooo_rf_tag", 64'(rf_tag), 64'(i));
            check("ooo_rf_dt", 64'(rf_dt), 64'(i * 16));
            check("ooo_rf_regnm", 64'(rf_regnm), 64'(i));
            tick();
        end
        check("ooo_rf_idle", 64'(rf_en), 64'd0);
        check("ooo_count", 64'(count), 64'd0);

        // Same-tag ex and lsb writeback: ex data wins.
        alloc(REG_W'(4), 1'b0, 1'b0);
        ex_wb(4, 32'hAA, 1'b0, '0);
        lsb_en  = 1'b1;
        lsb_tag = TAG_W'(4);
        lsb_dt  = 32'hBB;
        tick();
        ex_en  = 1'b0;
        lsb_en = 1'b0;
        tick();
        check("exwin_rf_tag", 64'(rf_tag), 64'd4);
        check("exwin_rf_dt", 64'(rf_dt), 64'hAA);

        // Store at head blocks a completed younger entry until acknowledged.
        alloc(REG_W'(0), 1'b1, 1'b0);
        alloc(REG_W'(6), 1'b0, 1'b0);
        ex_wb(6, 32'h60, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            check("st_wait_req", 64'(st_req), 64'd1);
            check("st_wait_tag", 64'(st_tag), 64'd5);
            check("st_wait_rf_en", 64'(rf_en), 64'd0);
            tick();
            ex_en = 1'b0;
        end
        st_ack = 1'b1;
        #1;
        check("st_ack_req", 64'(st_req), 64'd1);
        tick();
        st_ack = 1'b0;
        #1;
        check("st_drop", 64'(st_req), 64'd0);
        check("st_no_rf_yet", 64'(rf_en), 64'd0);
        tick();
        check("st_after_rf_en", 64'(rf_en), 64'd1);
        check("st_after_rf_tag", 64'(rf_tag), 64'd6);
        check("st_after_rf_dt", 64'(rf_dt), 64'h60);

        // Mispredicted branch at tag 7 with younger tags 8..10 in flight.
        for (int i = 7; i <= 10; i++) alloc(REG_W'(i), 1'b0, 1'b0);
        check("br_count", 64'(count), 64'd4);
        ex_wb(7, 32'h77, 1'b1, 32'h1000);
        tick();
        ex_wb(8, 32'h88, 1'b0, '0);
        tick();
        ex_en    = 1'b0;
        alloc_en = 1'b1;
        #1;
        check("br_clr", 64'(clr), 64'd1);
        check("br_clr_pc", 64'(clr_pc), 64'h1000);
        check("br_alloc_blocked", 64'(alloc_ok), 64'd0);
        check("br_rf_tag", 64'(rf_tag), 64'd7);
        check("br_count_clr", 64'(count), 64'd3);
        alloc_en = 1'b0;
        tick();
        check("br_clr_done", 64'(clr), 64'd0);
        check("br_flush_count", 64'(count), 64'd0);
        check("br_flush_tag", 64'(alloc_tag), 64'd1);
        check("br_flush_rf", 64'(rf_en), 64'd0);
        tick();
        check("br_no_commit_8", 64'(rf_en), 64'd0);

        // Advance tail to 31 with regnm 0 entries, drain, then wrap.
        for (int i = 1; i <= 30; i++) alloc(REG_W'(0), 1'b0, 1'b0);
        check("wrap_count", 64'(count), 64'd30);
        for (int i = 1; i <= 30; i++) begin
            ex_wb(i, DATA_W'(i), 1'b0, '0);
            tick();
            check("drain_rf_en", 64'(rf_en), 64'd0);
        end
        ex_en  = 1'b0;
        waited = 0;
        while (count != '0 && waited < 20) begin
            tick();
            waited++;
        end
        check("drain_timeout", 64'(waited < 20), 64'd1);
        alloc_en    = 1'b1;
        alloc_regnm = REG_W'(31);
        #1;
        check("wrap_tag31", 64'(alloc_tag), 64'd31);
        tick();
        alloc_regnm = REG_W'(0);
        #1;
        check("wrap_tag1", 64'(alloc_tag), 64'd1);
        tick();
        alloc_en = 1'b0;
        ex_wb(31, 32'h31, 1'b0, '0);
        tick();
        ex_en       = 1'b0;
        alloc_en    = 1'b1;
        alloc_store = 1'b1;
        #1;
        check("wrap_tag2", 64'(alloc_tag), 64'd2);
        tick();
        alloc_en    = 1'b0;
        alloc_store = 1'b0;
        check("same_cycle_count", 64'(count), 64'd2);
        check("wrap_rf_tag", 64'(rf_tag), 64'd31);
        check("wrap_rf_en", 64'(rf_en), 64'd1);
        ex_wb(1, 32'h1, 1'b0, '0);
        tick();
        ex_en = 1'b0;
        tick();
        check("rz_rf_en", 64'(rf_en), 64'd0);
        check("rst_st_pre_req", 64'(st_req), 64'd1);
        check("rst_st_pre_tag", 64'(st_tag), 64'd2);

        // Reset while a store request is pending.
        rst = 1'b0;
        tick();
        check("rst2_st_req", 64'(st_req), 64'd0);
        check("rst2_st_tag", 64'(st_tag), 64'd0);
        check("rst2_count", 64'(count), 64'd0);
        check("rst2_rf_tag", 64'(rf_tag), 64'd0);
        check("rst2_clr_pc", 64'(clr_pc), 64'd0);
        check("rst2_alloc_tag", 64'(alloc_tag), 64'd1);
        rst = 1'b1;

        // rdy low freezes commit and masks the rf_en pulse.
        alloc(REG_W'(3), 1'b0, 1'b0);
        ex_wb(1, 32'h99, 1'b0, '0);
        tick();
        ex_en = 1'b0;
        rdy   = 1'b0;
        tick();
        check("rdy_frozen_rf", 64'(rf_en), 64'd0);
        check("rdy_frozen_count", 64'(count), 64'd1);
        rdy = 1'b1;
        tick();
        check("rdy_rf_en", 64'(rf_en), 64'd1);
        check("rdy_rf_dt", 64'(rf_dt), 64'h99);
        rdy = 1'b0;
        #1;
        check("rdy_mask_rf", 64'(rf_en), 64'd0);
        rdy = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reorder_queue.md
REORDER_QUEUE -- requirements
Module: reorder_queue

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 32, slot count (power of 2); tag 0 reserved as "no tag", usable tags 1..DEPTH-1
- TAG_W, $clog2(DEPTH), tag width
- REG_W, 5, architectural register name width
- DATA_W, 32, result data width
- ADDR_W, 32, jump target width
REQ-002 Ports (name, direction, width, meaning), one per line, clock and reset first:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low
- rdy  in  1  global enable; when low, all state frozen and pulse outputs deasserted
- full  out  1  no free slot
- alloc_en  in  1  decode requests a slot
- alloc_regnm  in  REG_W  destination register
- alloc_store  in  1  entry is a store
- alloc_pd  in  1  predicted-jump bit
- alloc_ok  out  1  request accepted this cycle (combinational)
- alloc_tag  out  TAG_W  tag granted (combinational)
- ex_en, ex_tag, ex_dt, ex_ac, ex_j_pc  in  1/TAG_W/DATA_W/1/ADDR_W  ALU/branch writeback
- lsb_en, lsb_tag, lsb_dt  in  1/TAG_W/DATA_W  load writeback
- st_req  out  1  head store may execute; st_tag  out  TAG_W
- st_ack  in  1  store buffer has performed the head store
- rf_en  out  1  commit write; rf_regnm  out  REG_W; rf_dt  out  DATA_W; rf_tag  out  TAG_W
- clr  out  1  mispredict flush pulse; clr_pc  out  ADDR_W  redirect target
- count  out  TAG_W  occupied slot count

Function
REQ-003 Capacity is DEPTH-1; full is asserted when count==DEPTH-1 (registered, so a same-cycle commit does not free space for allocation).
REQ-004 alloc_ok = alloc_en & !full & !clr & rst; alloc_tag = tail; tail advances on alloc_ok, wrapping DEPTH-1 -> 1.
REQ-005 Writeback sets done, dt, ac and j_pc of the tagged slot; a writeback to an unoccupied slot or tag 0 is ignored; when ex and lsb target the same tag, ex wins.
REQ-006 Commit, at most one per cycle, applies to the head slot only, when it is occupied:
- non-store with done: rf_en=1 for one cycle with rf_regnm/rf_dt/rf_tag of head (rf_en=0 when regnm==0); slot freed; head advances.
- store: st_req=1 with st_tag=head while waiting; on st_ack, slot freed, head advances, st_req drops the next cycle.
REQ-007 Mispredict: a committing non-store with ac!=pd additionally drives clr=1 and clr_pc=j_pc for one cycle; the next cycle all slots are invalid, head=tail=1, count=0.
REQ-008 Flush has priority: during the clr cycle, alloc_ok=0 and writebacks are dropped.
REQ-009 Simultaneous alloc and commit leave count unchanged; count never exceeds DEPTH-1 and never underflows.
REQ-010 rf_en, clr and st_req are deasserted in any cycle where rdy=0.

Reset
REQ-011 On rst=0 at a clock edge: all slots invalid, head=tail=1, count=0, full=0, rf_en=0, clr=0, st_req=0, and rf_regnm, rf_dt, rf_tag, st_tag and clr_pc all 0.
REQ-012 Reset asserted mid-operation (including during a pending st_req or clr) discards everything with no completion pulses.

Configuration
REQ-013 Macro ROB_QUERY_EN: when defined, adds two read ports (q0_tag/q1_tag in TAG_W; q0_rdy/q1_rdy out 1; q0_dt/q1_dt out DATA_W) returning the slot's done flag and data combinationally, with same-cycle ex/lsb writeback forwarded; when undefined, these ports are absent and behaviour is otherwise identical.

Structure
REQ-014 The shared package holds the TAG_NONE=0 constant, the jump-bit encodings, and the entry record type (occupied, done, store, regnm, dt, pd, ac, j_pc).
REQ-015 The one sub-module is rq_ptr, a wrapping pointer counter that skips 0; head and tail each use one instance.

Verification
REQ-016 Fill, DEPTH=32: 31 allocations with no commits -> tags 1..31 granted, full=1, 32nd alloc_ok=0.
REQ-017 Writebacks out of order to tags 3,1,2 with dt 0x30,0x10,0x20 -> rf_en pulses in tag order 1,2,3 with matching data on consecutive cycles.
REQ-018 Store at head (tag 5), st_ack held low 4 cycles -> st_req=1, st_tag=5 for 4 cycles, and tag 6 (done) is not committed before the ack.
REQ-019 Branch tag 7 with pd=0, ac=1, j_pc=0x1000 at head, tags 8..10 allocated -> clr=1 with clr_pc=0x1000 for one cycle; the next cycle count=0 and alloc_tag=1.
REQ-020 Wrap: advance tail to 31, commit everything, then allocate -> alloc_tag=1, never 0; rst=0 applied during st_req -> all outputs go to 0 at the next edge.
